eth_rx_preamble_strip: RTL and testbench

- Receive-side framing stage that sits directly upstream of the FCS checker.
- Takes raw GMII-style receive bytes, recognises the preamble and SFD (0x55 repeated, then 0xD5), and strips them.
- Forwards only the frame bytes (destination MAC through FCS) with a valid strobe and a start-of-frame pulse, which is the input contract of the FCS checker.
- Also reports frame end, length, and framing errors.

---
 rtl/eth_rx_preamble_strip.sv | 140 ++++++++++++++
 tb/tb_eth_rx_preamble_strip.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/eth_rx_preamble_strip.sv
// Receive framing stage: finds 0x55 preamble + 0xD5 SFD on a GMII byte stream,
// strips them and forwards frame bytes with start/end/length/error reporting.
module eth_rx_preamble_strip #(
    parameter int unsigned MIN_PREAMBLE    = 7,
    parameter int unsigned MIN_FRAME_BYTES = 64,
    parameter int unsigned MAX_FRAME_BYTES = 1522
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic [7:0]  data_out,
    output logic        data_valid,
    output logic        preamble_sfd_valid,
    output logic        frame_done,
    output logic        frame_error,
    output logic [15:0] frame_len
);

    localparam logic [2:0]  MIN_PRE  = 3'(MIN_PREAMBLE);
    localparam logic [2:0]  PRE_SAT  = 3'd7;
    localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME_BYTES);
    localparam logic [15:0] MAX_LEN  = 16'(MAX_FRAME_BYTES);
    localparam logic [7:0]  BYTE_PRE = 8'h55;
    localparam logic [7:0]  BYTE_SFD = 8'hD5;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_DATA     = 2'd2,
        ST_DROP     = 2'd3
    } state_e;

    state_e      state_q;
    logic [2:0]  pre_cnt_q;
    logic [15:0] len_q;
    logic        err_q;
    logic        first_q;

    logic [15:0] len_d;
    logic [2:0]  pre_cnt_d;

    // Saturating/incrementing counter next values.
    always_comb begin
        len_d = len_q + 16'd1;
        if (pre_cnt_q == PRE_SAT) begin
            pre_cnt_d = pre_cnt_q;
        end else begin
            pre_cnt_d = pre_cnt_q + 3'd1;
        end
    end

    // Framing FSM with registered outputs; status strobes default low every cycle.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q            <= ST_IDLE;
            pre_cnt_q          <= 3'd0;
            len_q              <= 16'd0;
            err_q              <= 1'b0;
            first_q            <= 1'b0;
            data_out           <= 8'h00;
            data_valid         <= 1'b0;
            preamble_sfd_valid <= 1'b0;
            frame_done         <= 1'b0;
            frame_error        <= 1'b0;
            frame_len          <= 16'd0;
        end else begin
            data_valid         <= 1'b0;
            preamble_sfd_valid <= 1'b0;
            frame_done         <= 1'b0;
            frame_error        <= 1'b0;
            frame_len          <= 16'd0;
            case (state_q)
                ST_IDLE: begin
                    if (!gmii_rx_dv) begin
                        state_q <= ST_IDLE;
                    end else if (gmii_rxd == BYTE_PRE && !gmii_rx_er) begin
                        state_q   <= ST_PREAMBLE;
                        pre_cnt_q <= 3'd1;
                    end else begin
                        state_q <= ST_DROP;
                    end
                end
                ST_PREAMBLE: begin
                    if (!gmii_rx_dv) begin
                        state_q <= ST_IDLE;
                    end else if (gmii_rx_er) begin
                        state_q <= ST_DROP;
                    end else if (gmii_rxd == BYTE_PRE) begin
                        pre_cnt_q <= pre_cnt_d;
                    end else if (gmii_rxd == BYTE_SFD && pre_cnt_q >= MIN_PRE) begin
                        state_q <= ST_DATA;
                        len_q   <= 16'd0;
                        err_q   <= 1'b0;
                        first_q <= 1'b1;
                    end else begin
                        state_q <= ST_DROP;
                    end
                end
                ST_DATA: begin
                    if (!gmii_rx_dv) begin
                        frame_done  <= 1'b1;
                        frame_len   <= len_q;
                        frame_error <= err_q || (len_q < MIN_LEN);
                        state_q     <= ST_IDLE;
                    end else if (len_q == MAX_LEN) begin
                        // Oversize: close the frame now and discard the rest of it.
                        frame_done  <= 1'b1;
                        frame_len   <= MAX_LEN;
                        frame_error <= 1'b1;
                        state_q     <= ST_DROP;
                    end else begin
                        data_out           <= gmii_rxd;
                        data_valid         <= 1'b1;
                        preamble_sfd_valid <= first_q;
                        first_q            <= 1'b0;
                        len_q              <= len_d;
                        if (gmii_rx_er) begin
                            err_q <= 1'b1;
                        end else begin
                            err_q <= err_q;
                        end
                    end
                end
                ST_DROP: begin
                    if (!gmii_rx_dv) begin
                        state_q <= ST_IDLE;
                    end else begin
                        state_q <= ST_DROP;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eth_rx_preamble_strip.sv
// Scoreboard bench for eth_rx_preamble_strip: a frame-level reference model queues
// expected output events, a monitor pops and compares them as the DUT emits them.
module tb_eth_rx_preamble_strip;

    localparam int MIN_PRE = 7;
    localparam int MIN_LEN = 64;
    localparam int MAX_LEN = 1522;

    logic        aclk;
    logic        aresetn;
    logic [7:0]  gmii_rxd;
    logic        gmii_rx_dv;
    logic        gmii_rx_er;
    logic [7:0]  data_out;
    logic        data_valid;
    logic        preamble_sfd_valid;
    logic        frame_done;
    logic        frame_error;
    logic [15:0] frame_len;

    typedef struct packed {
        logic        is_done;
        logic [7:0]  d;
        logic        sof;
        logic [15:0] len;
        logic        err;
    } ev_t;

    ev_t        exp_q[$];
    logic [7:0] pay[$];
    int         checks   = 0;
    int         failures = 0;

    eth_rx_preamble_strip #(
        .MIN_PREAMBLE   (MIN_PRE),
        .MIN_FRAME_BYTES(MIN_LEN),
        .MAX_FRAME_BYTES(MAX_LEN)
    ) dut (
        .aclk              (aclk),
        .aresetn           (aresetn),
        .gmii_rxd          (gmii_rxd),
        .gmii_rx_dv        (gmii_rx_dv),
        .gmii_rx_er        (gmii_rx_er),
        .data_out          (data_out),
        .data_valid        (data_valid),
        .preamble_sfd_valid(preamble_sfd_valid),
        .frame_done        (frame_done),
        .frame_error       (frame_error),
        .frame_len         (frame_len)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every output event must match the head of the expectation queue.
    always @(posedge aclk) begin
        ev_t e;
        #1;
        check("valid_done_overlap", 32'(data_valid & frame_done), 32'd0);
        if (data_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_data: got byte 0x%0h expected no output", data_out);
            end else begin
                e = exp_q.pop_front();
                check("data_kind", 32'(e.is_done), 32'd0);
                check("data_byte", 32'(data_out), 32'(e.d));
                check("sof_pulse", 32'(preamble_sfd_valid), 32'(e.sof));
            end
        end else begin
            check("sof_without_data", 32'(preamble_sfd_valid), 32'd0);
        end
        if (frame_done) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done: got len %0d expected no output", frame_len);
            end else begin
                e = exp_q.pop_front();
                check("done_kind", 32'(e.is_done), 32'd1);
                check("frame_len", 32'(frame_len), 32'(e.len));
                check("frame_error", 32'(frame_error), 32'(e.err));
            end
        end else begin
            check("idle_len_zero", 32'(frame_len), 32'd0);
            check("idle_err_zero", 32'(frame_error), 32'd0);
        end
    end

    task automatic drive(input logic dv, input logic [7:0] d, input logic er);
        @(negedge aclk);
        gmii_rx_dv = dv;
        gmii_rxd   = d;
        gmii_rx_er = er;
    endtask

    task automatic push_data(input logic [7:0] d, input logic sof);
        ev_t e;
        e = '{is_done: 1'b0, d: d, sof: sof, len: 16'd0, err: 1'b0};
        exp_q.push_back(e);
    endtask

    // Reference model at frame level: accepted frames forward min(n,MAX) bytes then one done event.
    task automatic send_frame(input int npre, input logic [7:0] sfd, input int er_idx,
                              input bit pre_er, input int gap);
        int fwd;
        bit err;
        ev_t e;
        if (npre >= MIN_PRE && sfd == 8'hD5 && !pre_er) begin
            fwd = (pay.size() > MAX_LEN) ? MAX_LEN : pay.size();
            err = (pay.size() > MAX_LEN) || (er_idx >= 0 && er_idx < fwd) || (fwd < MIN_LEN);
            for (int i = 0; i < fwd; i++) push_data(pay[i], (i == 0));
            e = '{is_done: 1'b1, d: 8'h00, sof: 1'b0, len: 16'(fwd), err: err};
            exp_q.push_back(e);
        end
        for (int i = 0; i < npre; i++) drive(1'b1, 8'h55, pre_er && (i == 0));
        drive(1'b1, sfd, pre_er && (npre == 0));
        for (int i = 0; i < pay.size(); i++) drive(1'b1, pay[i], (i == er_idx));
        for (int i = 0; i < gap; i++) drive(1'b0, 8'h00, 1'b0);
    endtask

    task automatic fill_ramp(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'(i));
    endtask

    task automatic fill_rand(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge aclk);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n, np, er_idx, gap;
        logic [7:0] sfd;
        bit pre_er;

        aresetn    = 1'b0;
        gmii_rx_dv = 1'b0;
        gmii_rxd   = 8'h00;
        gmii_rx_er = 1'b0;
        repeat (3) @(negedge aclk);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_sof", 32'(preamble_sfd_valid), 32'd0);
        check("rst_done", 32'(frame_done), 32'd0);
        check("rst_len", 32'(frame_len), 32'd0);
        aresetn = 1'b1;
        drive(1'b0, 8'h00, 1'b0);

        // Nominal 64-byte ramp frame.
        fill_ramp(64);
        send_frame(7, 8'hD5, -1, 1'b0, 2);
        // Short preamble is rejected, following frame accepted.
        send_frame(3, 8'hD5, -1, 1'b0, 1);
        send_frame(7, 8'hD5, -1, 1'b0, 1);
        // Receive error on byte 10.
        send_frame(7, 8'hD5, 10, 1'b0, 1);
        // Oversize frame truncated at MAX, then a 1-cycle gap and a good frame.
        fill_rand(1600);
        send_frame(7, 8'hD5, -1, 1'b0, 1);
        fill_ramp(64);
        send_frame(7, 8'hD5, -1, 1'b0, 1);
        // Runt frame, then zero-byte frame.
        fill_ramp(20);
        send_frame(7, 8'hD5, -1, 1'b0, 1);
        pay.delete();
        send_frame(7, 8'hD5, -1, 1'b0, 1);
        // Extended preamble saturates the counter but is still accepted.
        fill_ramp(64);
        send_frame(9, 8'hD5, -1, 1'b0, 1);
        drain("drain_directed");

        // Reset asserted on byte 30 of a frame: tail must be dropped.
        fill_ramp(64);
        for (int i = 0; i < 30; i++) push_data(pay[i], (i == 0));
        for (int i = 0; i < 7; i++) drive(1'b1, 8'h55, 1'b0);
        drive(1'b1, 8'hD5, 1'b0);
        for (int i = 0; i < 30; i++) drive(1'b1, pay[i], 1'b0);
        @(negedge aclk);
        aresetn  = 1'b0;
        gmii_rxd = pay[30];
        #1;
        check("midrst_valid", 32'(data_valid), 32'd0);
        check("midrst_done", 32'(frame_done), 32'd0);
        check("midrst_len", 32'(frame_len), 32'd0);
        check("midrst_consumed", 32'(exp_q.size()), 32'd0);
        @(negedge aclk);
        aresetn  = 1'b1;
        gmii_rxd = pay[31];
        for (int i = 32; i < 64; i++) drive(1'b1, pay[i], 1'b0);
        drive(1'b0, 8'h00, 1'b0);
        send_frame(7, 8'hD5, -1, 1'b0, 1);
        drain("drain_reset");

        // Randomized frames.
        for (int f = 0; f < 40; f++) begin
            n      = $urandom_range(0, 100);
            np     = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 9) : $urandom_range(7, 9);
            sfd    = ($urandom_range(0, 7) == 0) ? 8'h5D : 8'hD5;
            er_idx = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 100) : -1;
            pre_er = ($urandom_range(0, 9) == 0);
            gap    = $urandom_range(1, 3);
            fill_rand(n);
            send_frame(np, sfd, er_idx, pre_er, gap);
        end
        drain("drain_random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
